regfile_clr: RTL



---
 rtl/regfile_clr.sv | 123 ++++++++++++
 1 files changed

// File: rtl/regfile_clr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_clr                                                |
// | Description : Integer register file, 2**AW entries of XLEN bits, with    |
// |               two combinational read ports, one synchronous write port,  |
// |               optional hardwired-zero entry 0 and a reset-triggered      |
// |               clear sweep that zeroes every entry one per cycle.         |
// | Ports       : clk  - clock, all state updates on rising edge             |
// |               rst  - synchronous active-high reset, restarts the sweep   |
// |               we   - write enable                                        |
// |               a1   - read address, port 1    rd1 - read data, port 1     |
// |               a2   - read address, port 2    rd2 - read data, port 2     |
// |               a3   - write address           wd3 - write data            |
// |               busy - clear sweep in progress (reads 0, writes dropped)   |
// | Options     : REGFILE_BYPASS_EN - when defined, a write in READY is      |
// |               forwarded to a read port addressing the same entry in the  |
// |               same cycle (write-first). Undefined: read-first.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_clr #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   input  logic [AW-1:0]   a3,
   input  logic [XLEN-1:0] wd3,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy
);

   localparam int          NREGS      = 2 ** AW;
   localparam logic [AW-1:0] c_LAST_IDX = '1;

`ifdef REGFILE_BYPASS_EN
   localparam logic c_BYPASS = 1'b1;
`else
   localparam logic c_BYPASS = 1'b0;
`endif

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_clr_idx;
   logic [XLEN-1:0]   r_mem [NREGS];
   logic              w_wr_ok;
   logic [AW-1:0]     w_raddr [2];
   logic [XLEN-1:0]   w_rdata [2];

   // A write is architecturally visible only outside the sweep and never to
   // the hardwired-zero entry.
   assign w_wr_ok = we && (r_state == S_READY) &&
                    !((ZERO_REG != 0) && (a3 == '0));

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_CLEAR;
         r_clr_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_CLEAR: if (r_clr_idx == c_LAST_IDX) w_state_nxt = S_READY;
         S_READY: w_state_nxt = S_READY;
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   assign busy = (r_state == S_CLEAR);

   // -------------------------------------------------------------- storage
   // Reset itself leaves the array alone; the sweep that follows zeroes it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
         end else if (w_wr_ok) begin
            r_mem[a3] <= wd3;
         end
      end
   end

   // ----------------------------------------------------------- read ports
   assign w_raddr[0] = a1;
   assign w_raddr[1] = a2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
         w_rdata[gi] = '0;
         if (r_state == S_READY) begin
            if ((ZERO_REG != 0) && (w_raddr[gi] == '0)) begin
               w_rdata[gi] = '0;
            end else if (c_BYPASS && w_wr_ok && (w_raddr[gi] == a3)) begin
               w_rdata[gi] = wd3;
            end else begin
               w_rdata[gi] = r_mem[w_raddr[gi]];
            end
         end
      end
   end

   assign rd1 = w_rdata[0];
   assign rd2 = w_rdata[1];

endmodule
`default_nettype wire
